instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch (IF) stage of the 5-stage RISC-V pipeline. Acts as the requester on the instruction-memory read port: it owns the PC, drives the word address, captures the returned instruction, and buffers fetched {pc, instr} pairs in a small fetch queue. The queue feeds the decode stage through a valid/ready handshake. Branch/jump redirects from EX flush the queue and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000: byte address fetched first after reset
- FQ_DEPTH, 2: fetch-queue entries; power of two, 2..8
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- imem_addr  output  32  word index to instruction memory, = {2'b00, pc[31:2]}
- imem_instr  input  32  combinational read data for imem_addr, same cycle
- redirect_valid  input  1  EX requests PC redirect this cycle
- redirect_target  input  32  byte address of new PC
- id_valid  output  1  queue head holds a valid instruction
- id_ready  input  1  decode accepts head this cycle
- id_instr  output  32  instruction at queue head
- id_pc  output  32  byte PC of id_instr
- misalign_err  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: pc (32b), queue of FQ_DEPTH × {pc, instr}, rd/wr pointers, count (clog2(FQ_DEPTH)+1 bits).
- Pop: id_valid && id_ready removes head.
- Push: fetch when count < FQ_DEPTH, or count == FQ_DEPTH with a pop in the same cycle; push {pc, imem_instr} at tail; pc <= pc + 4 (mod 2^32, wraps silently).
- No push: pc holds.
- id_valid = (count != 0); id_instr/id_pc = head entry; head fields undefined-but-stable when id_valid = 0.
- Redirect (redirect_valid = 1): queue emptied (count, pointers to 0), pc <= {redirect_target[31:2], 2'b00}, no push and no pop that cycle regardless of id_ready. Overrides push/pop.
- Priority: reset > redirect > pop/push.
- Pointers wrap modulo FQ_DEPTH; count never exceeds FQ_DEPTH nor goes below 0.

## Timing
- Reset values: pc = RESET_PC, count = 0, id_valid = 0, id_instr = 0, id_pc = 0, misalign_err = 0, imem_addr = RESET_PC >> 2.
- Reset mid-operation: all queued entries dropped next edge; identical to power-on reset.
- Fetch latency: first cycle after reset deasserts pushes RESET_PC; id_valid = 1 the following cycle.
- Redirect asserted in cycle N: cycle N+1 imem_addr = target>>2 and pushes; cycle N+2 id_valid = 1, id_pc = target. Penalty 2 cycles.
- Steady state with id_ready held 1: one instruction per cycle, consecutive id_pc differ by 4.
- id_ready = 0 with queue full: no push, pc and imem_addr frozen, head stable.
- Simultaneous push and pop at full: both occur, count unchanged.

## Configuration
- IFU_MISALIGN_CHECK_EN defined: redirect with redirect_target[1:0] != 0 sets misalign_err (sticky until reset); the redirect flush still happens, pc loads the aligned target, and further fetch is blocked (no push) while misalign_err = 1. Already-queued entries are none (flushed), so id_valid stays 0.
- Not defined: target[1:0] silently dropped; misalign_err tied 0.

## Structure
- Shared pipeline package: RESET_PC default, word-address shift constant (2), fetch-entry record {pc, instr}, NOP encoding 32'h0000_0013 for downstream bubble insertion.
- One sub-module: ifu_fetch_queue (parameterised FIFO with push/pop/flush, count, head outputs); PC logic and redirect handling in the top.

## Test plan
- Reset, bench imem returns 32'hA000_0000 | word index, id_ready = 1 -> first id_valid cycle id_pc = 0, id_instr = 32'hA000_0000; next id_pc = 4, id_instr = 32'hA000_0001.
- id_ready = 0 for 5 cycles after reset -> queue fills to 2 entries (pc 0, 4); imem_addr frozen at 2; release id_ready -> pcs 0, 4, 8 delivered in order, no gaps or duplicates.
- Redirect to 32'h0000_0040 in cycle N with 2 entries queued -> queued entries discarded; cycle N+2 id_pc = 0x40, id_instr = 32'hA000_0010.
- Redirect and id_ready = 1 same cycle with queue full -> no entry consumed, queue empty next cycle.
- Reset asserted while queue full and redirect_valid = 1 -> next cycle id_valid = 0, imem_addr = 0, pc = RESET_PC.
- With IFU_MISALIGN_CHECK_EN, redirect to 32'h0000_0042 -> misalign_err = 1 next cycle, id_valid stays 0 indefinitely; without macro -> id_pc = 0x40 at N+2, misalign_err = 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared pipeline constants and the fetch-entry record.
package instr_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int WORD_SHIFT = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: small FIFO of fetched {pc, instr} entries with flush.
module ifu_fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wr_data,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count
);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_wr_data;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage owning the PC, feeding decode through a fetch queue.
// Optional IFU_MISALIGN_CHECK_EN flags misaligned redirects and halts fetch.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        misalign_err
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);
  logic [31:0] r_pc;
  logic [CW-1:0] w_count;
  logic w_pop, w_push, w_unused;
  fetch_entry_t w_head;
  assign id_valid = w_count != '0;
  assign id_pc = w_head.pc;
  assign id_instr = w_head.instr;
  assign imem_addr = r_pc >> WORD_SHIFT;
  // Redirect overrides both queue ports for the cycle.
  assign w_pop = id_valid && id_ready && !redirect_valid;
  assign w_push = !redirect_valid && !misalign_err && (w_count != FULL || w_pop);
`ifdef IFU_MISALIGN_CHECK_EN
  logic r_misalign;
  assign misalign_err = r_misalign;
  assign w_unused = ^r_pc[1:0];
  always_ff @(posedge clk) begin
    if (reset) r_misalign <= 1'b0;
    else if (redirect_valid && redirect_target[1:0] != 2'b00) r_misalign <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
  assign w_unused = ^{r_pc[1:0], redirect_target[1:0]};
`endif
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= {redirect_target[31:2], 2'b00};
    else if (w_push) r_pc <= r_pc + 32'd4;
  end
  ifu_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (redirect_valid),
    .i_wr_data ('{pc: r_pc, instr: imem_instr}),
    .o_head    (w_head),
    .o_count   (w_count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, backpressure, redirect, reset and wrap.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset, redirect_valid, id_ready, id_valid, misalign_err;
  logic [31:0] imem_addr, imem_instr, redirect_target, id_instr, id_pc;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  assign imem_instr = 32'hA000_0000 | imem_addr;
  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .misalign_err    (misalign_err)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready = 1'b1;
    step(2);
    check("rst_valid", 32'(id_valid), 0);
    check("rst_instr", id_instr, 0);
    check("rst_pc", id_pc, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_mis", 32'(misalign_err), 0);
    reset = 1'b0;
    step();
    check("first_valid", 32'(id_valid), 1);
    check("first_pc", id_pc, 32'h0);
    check("first_instr", id_instr, 32'hA000_0000);
    step();
    check("second_pc", id_pc, 32'h4);
    check("second_instr", id_instr, 32'hA000_0001);
    // backpressure: queue fills with pc 0 and 4, fetch freezes at word 2
    reset = 1'b1;
    id_ready = 1'b0;
    step();
    reset = 1'b0;
    step(5);
    check("bp_addr", imem_addr, 32'h2);
    check("bp_valid", 32'(id_valid), 1);
    check("bp_head", id_pc, 32'h0);
    check("bp_instr", id_instr, 32'hA000_0000);
    id_ready = 1'b1;
    step();
    check("rel_pc1", id_pc, 32'h4);
    step();
    check("rel_pc2", id_pc, 32'h8);
    step();
    check("rel_pc3", id_pc, 32'hC);
    id_ready = 1'b0;
    step();
    check("full_head", id_pc, 32'hC);
    // redirect with full queue and id_ready=1
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0040;
    id_ready = 1'b1;
    step();
    check("redir_n1_valid", 32'(id_valid), 0);
    check("redir_n1_addr", imem_addr, 32'h10);
    redirect_valid = 1'b0;
    step();
    check("redir_n2_valid", 32'(id_valid), 1);
    check("redir_n2_pc", id_pc, 32'h40);
    check("redir_n2_instr", id_instr, 32'hA000_0010);
    step();
    check("redir_next_pc", id_pc, 32'h44);
    // reset beats redirect while full
    id_ready = 1'b0;
    step(2);
    check("pre_rst_valid", 32'(id_valid), 1);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0080;
    step();
    check("rst_redir_valid", 32'(id_valid), 0);
    check("rst_redir_addr", imem_addr, 32'h0);
    reset = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    check("restart_pc", id_pc, 32'h0);
    // pc wraps from the top of the address space
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_pc_hi", id_pc, 32'hFFFF_FFFC);
    check("wrap_instr_hi", id_instr, 32'hBFFF_FFFF);
    step();
    check("wrap_pc_lo", id_pc, 32'h0);
    check("wrap_instr_lo", id_instr, 32'hA000_0000);
    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0042;
    step();
    check("mis_n1_addr", imem_addr, 32'h10);
    check("mis_n1_valid", 32'(id_valid), 0);
`ifdef IFU_MISALIGN_CHECK_EN
    check("mis_n1_err", 32'(misalign_err), 1);
    redirect_valid = 1'b0;
    step();
    check("mis_n2_valid", 32'(id_valid), 0);
    step(3);
    check("mis_hold_valid", 32'(id_valid), 0);
    check("mis_hold_addr", imem_addr, 32'h10);
    check("mis_hold_err", 32'(misalign_err), 1);
`else
    check("mis_n1_err", 32'(misalign_err), 0);
    redirect_valid = 1'b0;
    step();
    check("mis_n2_valid", 32'(id_valid), 1);
    check("mis_n2_pc", id_pc, 32'h40);
    step(3);
    check("mis_later_pc", id_pc, 32'h4C);
    check("mis_later_err", 32'(misalign_err), 0);
`endif
    reset = 1'b1;
    step();
    check("final_rst_err", 32'(misalign_err), 0);
    check("final_rst_valid", 32'(id_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
